// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the ID-stage forwarding/hazard control slice:
// operand-mux select codes, the shadow pipeline entry and mult/div latencies.
package cpu_ctrl_pkg;

   // Operand mux select codes (rs and rt paths use the same encoding)
   localparam logic [1:0] SEL_RF  = 2'b00;  // register file read data
   localparam logic [1:0] SEL_EX  = 2'b01;  // EX-stage result
   localparam logic [1:0] SEL_MEM = 2'b10;  // MEM-stage result (load data for loads)
   localparam logic [1:0] SEL_WB  = 2'b11;  // WB-stage result

   // Default busy lengths of the multi-cycle mult/div unit
   localparam int MUL_CYCLES_DEF = 4;
   localparam int DIV_CYCLES_DEF = 16;

   // One shadow-scoreboard entry: a live GPR producer travelling down the pipe
   typedef struct packed {
      logic       v;   // entry holds a producer that writes a nonzero GPR
      logic [4:0] rd;  // destination register
      logic       ld;  // producer is a load (data only available from MEM)
   } shadow_t;

endpackage : cpu_ctrl_pkg

// File: rtl/fwd_sel_gen.sv
// Per-source forwarding select: picks the newest in-flight producer of the
// source register and flags a load-use conflict against the EX entry.
module fwd_sel_gen
   import cpu_ctrl_pkg::*;
(
   input  logic [4:0] src,
   input  logic       use_src,
   input  shadow_t    ex,
   input  shadow_t    mem,
   input  shadow_t    wb,
   output logic [1:0] sel,
   output logic       ld_hit
);

   logic src_live;
   logic hit_ex;
   logic hit_mem;
   logic hit_wb;

   // $0 is hard-wired zero, so it never forwards and never causes a hazard
   assign src_live = use_src & (src != 5'd0);
   assign hit_ex   = src_live & ex.v  & (ex.rd  == src);
   assign hit_mem  = src_live & mem.v & (mem.rd == src);
   assign hit_wb   = src_live & wb.v  & (wb.rd  == src);

   // Priority EX > MEM > WB so the youngest producer of the register wins
   always_comb begin
      sel = SEL_RF;
      if (hit_ex)
         sel = SEL_EX;
      else if (hit_mem)
         sel = SEL_MEM;
      else if (hit_wb)
         sel = SEL_WB;
   end

   // Load in EX has no data yet; the consumer must wait one cycle for MEM
   assign ld_hit = hit_ex & ex.ld;

endmodule : fwd_sel_gen

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller for ID-stage operand selection.
// Tracks EX/MEM/WB destination registers in a shadow scoreboard, drives the
// rs/rt operand mux selects, and stalls on load-use and busy mult/div hazards.
module fwd_hazard_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int MUL_CYCLES = MUL_CYCLES_DEF,
   parameter int DIV_CYCLES = DIV_CYCLES_DEF
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       id_valid,
   input  logic       id_flush,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_use_rs,
   input  logic       id_use_rt,
   input  logic       id_wr_en,
   input  logic [4:0] id_rd,
   input  logic       id_is_load,
   input  logic       id_md_start,
   input  logic       id_md_div,
   input  logic       id_use_hilo,
   output logic [1:0] sel_rs,
   output logic [1:0] sel_rt,
   output logic       stall,
   output logic       md_start,
   output logic       md_busy
);

   localparam logic [4:0] MUL_LOAD = 5'(MUL_CYCLES);
   localparam logic [4:0] DIV_LOAD = 5'(DIV_CYCLES);

   shadow_t    ex_reg, mem_reg, wb_reg;
   shadow_t    ex_next;
   logic [4:0] md_cnt_reg, md_cnt_next;

   logic       id_live;
   logic       load_use;
   logic       md_hazard;

   logic [4:0] src_arr [2];
   logic       use_arr [2];
   logic [1:0] sel_arr [2];
   logic       hit_arr [2];

   // A flushed ID slot behaves exactly like an empty one
   assign id_live = id_valid & ~id_flush;

   assign src_arr[0] = id_rs;
   assign src_arr[1] = id_rt;
   assign use_arr[0] = id_use_rs;
   assign use_arr[1] = id_use_rt;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_src
         fwd_sel_gen u_sel (
            .src     (src_arr[gi]),
            .use_src (use_arr[gi]),
            .ex      (ex_reg),
            .mem     (mem_reg),
            .wb      (wb_reg),
            .sel     (sel_arr[gi]),
            .ld_hit  (hit_arr[gi])
         );
      end
   endgenerate

   assign sel_rs = sel_arr[0];
   assign sel_rt = sel_arr[1];

   assign md_busy   = (md_cnt_reg != 5'd0);
   assign load_use  = id_live & (hit_arr[0] | hit_arr[1]);
   assign md_hazard = id_live & (id_use_hilo | id_md_start) & md_busy;
   assign stall     = load_use | md_hazard;
   // Stall gating also blocks a restart while the unit is still busy
   assign md_start  = id_live & id_md_start & ~stall;

   // Next EX entry: a real GPR producer, or a bubble when stalled/flushed/idle
   always_comb begin
      ex_next = '0;
      if (id_live && !stall && id_wr_en && (id_rd != 5'd0)) begin
         ex_next.v  = 1'b1;
         ex_next.rd = id_rd;
         ex_next.ld = id_is_load;
      end
   end

   // Mult/div busy counter: load on start, otherwise count down to zero
   always_comb begin
      md_cnt_next = md_cnt_reg;
      if (md_start)
         md_cnt_next = id_md_div ? DIV_LOAD : MUL_LOAD;
      else if (md_cnt_reg != 5'd0)
         md_cnt_next = md_cnt_reg - 5'd1;
   end

   // Shadow pipeline advance and counter update; reset aborts any operation
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_reg     <= '0;
         mem_reg    <= '0;
         wb_reg     <= '0;
         md_cnt_reg <= 5'd0;
      end else begin
         ex_reg     <= ex_next;
         mem_reg    <= ex_reg;
         wb_reg     <= mem_reg;
         md_cnt_reg <= md_cnt_next;
      end
   end

endmodule : fwd_hazard_ctrl

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed scenarios plus random
// traffic, compared against an issue-history reference model.
module tb_fwd_hazard_ctrl;

   localparam int MUL = 4;
   localparam int DIV = 16;

   logic       clk;
   logic       rst;
   logic       id_valid, id_flush;
   logic [4:0] id_rs, id_rt, id_rd;
   logic       id_use_rs, id_use_rt, id_wr_en, id_is_load;
   logic       id_md_start, id_md_div, id_use_hilo;
   logic [1:0] sel_rs, sel_rt;
   logic       stall, md_start, md_busy;

   fwd_hazard_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .id_valid    (id_valid),
      .id_flush    (id_flush),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_use_rs   (id_use_rs),
      .id_use_rt   (id_use_rt),
      .id_wr_en    (id_wr_en),
      .id_rd       (id_rd),
      .id_is_load  (id_is_load),
      .id_md_start (id_md_start),
      .id_md_div   (id_md_div),
      .id_use_hilo (id_use_hilo),
      .sel_rs      (sel_rs),
      .sel_rt      (sel_rt),
      .stall       (stall),
      .md_start    (md_start),
      .md_busy     (md_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: what was issued in each cycle (writes only)
   typedef struct packed {
      logic       w;
      logic [4:0] rd;
      logic       ld;
   } ent_t;

   ent_t hist [0:4095];
   int   cyc;
   int   md_s;
   int   md_len;
   logic exp_stall, exp_mds;
   int unsigned vectors;
   int unsigned miscompares;

   task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, got, exp);
      end
   endtask

   // Forward from the most recently issued writer of s within three cycles
   function automatic logic [1:0] model_sel(input logic [4:0] s, input logic u);
      if (!u || s == 5'd0) return 2'd0;
      for (int a = 1; a <= 3; a++)
         if (hist[cyc-a].w && hist[cyc-a].rd == s) return 2'(a);
      return 2'd0;
   endfunction

   task automatic set_in(input logic v, input logic fl,
                         input logic [4:0] rs, input logic urs,
                         input logic [4:0] rt, input logic urt,
                         input logic wr, input logic [4:0] rd, input logic ld,
                         input logic mds, input logic mdd, input logic hl);
      id_valid = v;   id_flush = fl;
      id_rs = rs;     id_use_rs = urs;
      id_rt = rt;     id_use_rt = urt;
      id_wr_en = wr;  id_rd = rd;   id_is_load = ld;
      id_md_start = mds; id_md_div = mdd; id_use_hilo = hl;
   endtask

   task automatic set_idle();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic check_model();
      logic live, lu, busy;
      ent_t e;
      live = id_valid && !id_flush;
      e    = hist[cyc-1];
      lu   = live && e.w && e.ld &&
             ((id_use_rs && id_rs != 0 && e.rd == id_rs) ||
              (id_use_rt && id_rt != 0 && e.rd == id_rt));
      busy = (cyc > md_s) && (cyc <= md_s + md_len);
      exp_stall = lu || (live && (id_use_hilo || id_md_start) && busy);
      exp_mds   = live && id_md_start && !exp_stall;
      chk("sel_rs",   5'(sel_rs),   5'(model_sel(id_rs, id_use_rs)));
      chk("sel_rt",   5'(sel_rt),   5'(model_sel(id_rt, id_use_rt)));
      chk("stall",    5'(stall),    5'(exp_stall));
      chk("md_start", 5'(md_start), 5'(exp_mds));
      chk("md_busy",  5'(md_busy),  5'(busy));
   endtask

   task automatic commit();
      ent_t e;
      e = '0;
      if (id_valid && !id_flush && !exp_stall) begin
         e.w  = id_wr_en && (id_rd != 0);
         e.rd = id_rd;
         e.ld = id_is_load;
      end
      hist[cyc] = e;
      if (exp_mds) begin
         md_s   = cyc;
         md_len = id_md_div ? DIV : MUL;
      end
      cyc++;
   endtask

   task automatic step(input logic v, input logic fl,
                       input logic [4:0] rs, input logic urs,
                       input logic [4:0] rt, input logic urt,
                       input logic wr, input logic [4:0] rd, input logic ld,
                       input logic mds, input logic mdd, input logic hl);
      @(negedge clk);
      set_in(v, fl, rs, urs, rt, urt, wr, rd, ld, mds, mdd, hl);
      #1;
      check_model();
      commit();
   endtask

   // Async reset with the current ID inputs still applied (md start held off)
   task automatic reset_now(input string tag);
      id_md_start = 1'b0;
      rst = 1'b1;
      #1;
      chk({tag, "_sel_rs"},   5'(sel_rs),   5'd0);
      chk({tag, "_sel_rt"},   5'(sel_rt),   5'd0);
      chk({tag, "_stall"},    5'(stall),    5'd0);
      chk({tag, "_md_start"}, 5'(md_start), 5'd0);
      chk({tag, "_md_busy"},  5'(md_busy),  5'd0);
      for (int a = 0; a <= 3; a++) hist[cyc-a] = '0;
      md_s = -1000;
      cyc++;
      @(negedge clk);
      rst = 1'b0;
      set_idle();
      #1;
      check_model();
      commit();
   endtask

   int stall_cnt;

   initial begin
      vectors = 0;
      miscompares = 0;
      for (int i = 0; i < 4096; i++) hist[i] = '0;
      cyc  = 4;
      md_s = -1000;
      md_len = 0;
      rst  = 1'b1;
      set_idle();
      @(negedge clk);
      #1;
      chk("rst_sel_rs", 5'(sel_rs), 5'd0);
      chk("rst_stall",  5'(stall),  5'd0);
      chk("rst_busy",   5'(md_busy), 5'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_model();
      commit();

      // Back-to-back ALU forwarding at distances 1, 2, 3
      step(1, 0, 1, 1, 2, 1, 1, 3, 0, 0, 0, 0);   // addu $3
      step(1, 0, 3, 1, 3, 1, 1, 4, 0, 0, 0, 0);   // addu $4,$3,$3 -> 01/01
      chk("fwd_ex_direct", 5'(sel_rs), 5'd1);
      step(1, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);   // reader of $3 -> 10
      chk("fwd_mem_direct", 5'(sel_rs), 5'd2);
      step(1, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);   // reader of $3 -> 11
      chk("fwd_wb_direct", 5'(sel_rs), 5'd3);

      // Load-use: one stall, then forwarding from MEM
      step(1, 0, 1, 1, 0, 0, 1, 5, 1, 0, 0, 0);   // lw $5
      step(1, 0, 5, 1, 0, 1, 1, 6, 0, 0, 0, 0);   // addu $6,$5,$0 stalls
      chk("lu_stall", 5'(stall), 5'd1);
      step(1, 0, 5, 1, 0, 1, 1, 6, 0, 0, 0, 0);   // retry -> 10
      chk("lu_after", 5'({stall, sel_rs}), 5'b0_10);

      // $0 writers and a reader that uses only rt
      step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
      step(1, 0, 0, 1, 0, 1, 1, 9, 0, 0, 0, 0);
      step(1, 0, 9, 0, 1, 1, 0, 0, 0, 0, 0, 0);   // rs=$9 match but unused

      // Newest producer wins
      step(1, 0, 1, 1, 1, 1, 1, 7, 0, 0, 0, 0);   // addu $7
      step(1, 0, 1, 1, 1, 1, 1, 7, 0, 0, 0, 0);   // subu $7
      step(1, 0, 7, 1, 7, 1, 0, 0, 0, 0, 0, 0);
      chk("newest_wins", 5'(sel_rt), 5'd1);

      // div then mflo waits out the busy window; same for mult
      for (int k = 0; k < 2; k++) begin
         step(1, 0, 1, 1, 2, 1, 0, 0, 0, 1, (k == 0), 0);
         stall_cnt = 0;
         for (int n = 0; n < 20; n++) begin
            step(1, 0, 0, 0, 0, 0, 1, 8, 0, 0, 0, 1);
            if (stall) stall_cnt++;
         end
         chk("md_stall_len", 5'(stall_cnt), (k == 0) ? 5'(DIV) : 5'(MUL));
      end

      // Async reset mid-div
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      #1;
      reset_now("rst_div");

      // Async reset mid-load-stall
      step(1, 0, 1, 1, 0, 0, 1, 5, 1, 0, 0, 0);
      @(negedge clk);
      set_in(1, 0, 5, 1, 0, 0, 1, 6, 0, 0, 0, 0);
      #1;
      chk("pre_rst_lu", 5'(stall), 5'd1);
      reset_now("rst_lu");

      // Flushed dependent of a load never stalls
      step(1, 0, 1, 1, 0, 0, 1, 5, 1, 0, 0, 0);
      step(1, 1, 5, 1, 5, 1, 1, 6, 0, 1, 0, 1);
      chk("flush_no_stall", 5'(stall), 5'd0);

      // Random traffic with occasional asynchronous resets
      for (int n = 0; n < 1500; n++) begin
         @(negedge clk);
         set_in($urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0,
                5'($urandom_range(0, 3)), $urandom_range(0, 9) < 7,
                5'($urandom_range(0, 3)), $urandom_range(0, 9) < 7,
                $urandom_range(0, 9) < 7, 5'($urandom_range(0, 3)),
                $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0,
                $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0);
         #1;
         check_model();
         if ($urandom_range(0, 249) == 0)
            reset_now("rnd_rst");
         else
            commit();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_fwd_hazard_ctrl
